// File: rtl/id_stage.sv
// rtl/id_stage.sv - MIPS instruction-decode stage with register file, ID/EX register and load-use detection
//
// Ports:
//   clk, reset (async, active-low)
//   IF_ID_Inst, IF_ID_NewPC          : instruction and PC+4 from IF/ID
//   flush                            : squash the instruction currently in ID
//   WB_RegWrite/WB_WriteReg/WB_WriteData : register-file write port
//   hazard                           : load-use stall request to IF (combinational)
//   ID_EX_*                          : registered control, operands, immediate and indices

module id_stage #(
  parameter int DATA_W    = 32,
  parameter int NREG      = 32,
  parameter int RF_BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       IF_ID_Inst,
  input  logic [31:0]       IF_ID_NewPC,
  input  logic              flush,
  input  logic              WB_RegWrite,
  input  logic [4:0]        WB_WriteReg,
  input  logic [DATA_W-1:0] WB_WriteData,
  output logic              hazard,
  output logic              ID_EX_RegWrite,
  output logic              ID_EX_MemtoReg,
  output logic              ID_EX_Branch,
  output logic              ID_EX_MemRead,
  output logic              ID_EX_MemWrite,
  output logic              ID_EX_RegDst,
  output logic              ID_EX_ALUSrc,
  output logic [1:0]        ID_EX_ALUOp,
  output logic [31:0]       ID_EX_NewPC,
  output logic [DATA_W-1:0] ID_EX_ReadData1,
  output logic [DATA_W-1:0] ID_EX_ReadData2,
  output logic [DATA_W-1:0] ID_EX_Imm,
  output logic [4:0]        ID_EX_Rs,
  output logic [4:0]        ID_EX_Rt,
  output logic [4:0]        ID_EX_Rd
);

  logic [DATA_W-1:0] rf [NREG];

  logic [5:0] opcode;
  logic [4:0] rs, rt, rd;
  logic       c_regwrite, c_memtoreg, c_branch, c_memread, c_memwrite, c_regdst, c_alusrc;
  logic [1:0] c_aluop;
  logic [DATA_W-1:0] rd1, rd2, imm;
  logic       raw_hz;

  assign opcode = IF_ID_Inst[31:26];
  assign rs     = IF_ID_Inst[25:21];
  assign rt     = IF_ID_Inst[20:16];
  assign rd     = IF_ID_Inst[15:11];
  assign imm    = {{(DATA_W-16){IF_ID_Inst[15]}}, IF_ID_Inst[15:0]};

  always_comb begin
    c_regwrite = 1'b0;
    c_memtoreg = 1'b0;
    c_branch   = 1'b0;
    c_memread  = 1'b0;
    c_memwrite = 1'b0;
    c_regdst   = 1'b0;
    c_alusrc   = 1'b0;
    c_aluop    = 2'b00;
    case (opcode)
      6'h00: begin c_regdst = 1'b1; c_regwrite = 1'b1; c_aluop = 2'b10; end
      6'h23: begin c_alusrc = 1'b1; c_memtoreg = 1'b1; c_regwrite = 1'b1; c_memread = 1'b1; end
      6'h2B: begin c_alusrc = 1'b1; c_memwrite = 1'b1; end
      6'h04: begin c_branch = 1'b1; c_aluop = 2'b01; end
      6'h08: begin c_alusrc = 1'b1; c_regwrite = 1'b1; end
      default: ;
    endcase
  end

  // $0 always reads zero; with bypass, a same-cycle write-back wins over the stored value.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs != 5'd0) begin
      rd1 = rf[rs];
      if (RF_BYPASS != 0 && WB_RegWrite && WB_WriteReg == rs) rd1 = WB_WriteData;
    end
    if (rt != 5'd0) begin
      rd2 = rf[rt];
      if (RF_BYPASS != 0 && WB_RegWrite && WB_WriteReg == rt) rd2 = WB_WriteData;
    end
  end

  // A load in EX whose destination feeds the instruction in ID must wait one cycle.
  assign raw_hz = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                  ((ID_EX_Rt == rs) || (ID_EX_Rt == rt));
  // A taken branch discards the waiting instruction anyway, so IF must be free to redirect.
  assign hazard = raw_hz && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (WB_RegWrite && WB_WriteReg != 5'd0) begin
      rf[WB_WriteReg] <= WB_WriteData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || flush || raw_hz) begin
      ID_EX_RegWrite  <= 1'b0;
      ID_EX_MemtoReg  <= 1'b0;
      ID_EX_Branch    <= 1'b0;
      ID_EX_MemRead   <= 1'b0;
      ID_EX_MemWrite  <= 1'b0;
      ID_EX_RegDst    <= 1'b0;
      ID_EX_ALUSrc    <= 1'b0;
      ID_EX_ALUOp     <= 2'b00;
      ID_EX_NewPC     <= '0;
      ID_EX_ReadData1 <= '0;
      ID_EX_ReadData2 <= '0;
      ID_EX_Imm       <= '0;
      ID_EX_Rs        <= '0;
      ID_EX_Rt        <= '0;
      ID_EX_Rd        <= '0;
    end else begin
      ID_EX_RegWrite  <= c_regwrite;
      ID_EX_MemtoReg  <= c_memtoreg;
      ID_EX_Branch    <= c_branch;
      ID_EX_MemRead   <= c_memread;
      ID_EX_MemWrite  <= c_memwrite;
      ID_EX_RegDst    <= c_regdst;
      ID_EX_ALUSrc    <= c_alusrc;
      ID_EX_ALUOp     <= c_aluop;
      ID_EX_NewPC     <= IF_ID_NewPC;
      ID_EX_ReadData1 <= rd1;
      ID_EX_ReadData2 <= rd2;
      ID_EX_Imm       <= imm;
      ID_EX_Rs        <= rs;
      ID_EX_Rt        <= rt;
      ID_EX_Rd        <= rd;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking bench for id_stage with a behavioural pipeline model

module tb_id_stage;

  typedef struct packed {
    logic        regwrite, memtoreg, branch, memread, memwrite, regdst, alusrc;
    logic [1:0]  aluop;
    logic [31:0] newpc, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
  } idex_t;

  localparam logic [31:0] NOP_INST = 32'hFC000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst, newpc, wb_data;
  logic        flush, wb_we;
  logic [4:0]  wb_reg;
  logic        hazard;
  logic        o_regwrite, o_memtoreg, o_branch, o_memread, o_memwrite, o_regdst, o_alusrc;
  logic [1:0]  o_aluop;
  logic [31:0] o_newpc, o_rd1, o_rd2, o_imm;
  logic [4:0]  o_rs, o_rt, o_rd;
  idex_t       obs;

  int passed = 0;
  int total  = 0;

  logic [31:0] m_rf [32];
  idex_t       m_idex;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .reset(reset), .IF_ID_Inst(inst), .IF_ID_NewPC(newpc), .flush(flush),
    .WB_RegWrite(wb_we), .WB_WriteReg(wb_reg), .WB_WriteData(wb_data), .hazard(hazard),
    .ID_EX_RegWrite(o_regwrite), .ID_EX_MemtoReg(o_memtoreg), .ID_EX_Branch(o_branch),
    .ID_EX_MemRead(o_memread), .ID_EX_MemWrite(o_memwrite), .ID_EX_RegDst(o_regdst),
    .ID_EX_ALUSrc(o_alusrc), .ID_EX_ALUOp(o_aluop), .ID_EX_NewPC(o_newpc),
    .ID_EX_ReadData1(o_rd1), .ID_EX_ReadData2(o_rd2), .ID_EX_Imm(o_imm),
    .ID_EX_Rs(o_rs), .ID_EX_Rt(o_rt), .ID_EX_Rd(o_rd)
  );

  assign obs = {o_regwrite, o_memtoreg, o_branch, o_memread, o_memwrite, o_regdst, o_alusrc,
                o_aluop, o_newpc, o_rd1, o_rd2, o_imm, o_rs, o_rt, o_rd};

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (wb_we && wb_reg == a) return wb_data;
    return m_rf[a];
  endfunction

  function automatic idex_t m_decode();
    idex_t d = '0;
    d.newpc = newpc;
    d.rs    = inst[25:21];
    d.rt    = inst[20:16];
    d.rd    = inst[15:11];
    d.rd1   = m_read(d.rs);
    d.rd2   = m_read(d.rt);
    d.imm   = 32'($signed(inst[15:0]));
    case (inst[31:26])
      6'h00: begin d.regdst = 1; d.regwrite = 1; d.aluop = 2; end
      6'h23: begin d.alusrc = 1; d.memtoreg = 1; d.regwrite = 1; d.memread = 1; end
      6'h2B: begin d.alusrc = 1; d.memwrite = 1; end
      6'h04: begin d.branch = 1; d.aluop = 1; end
      6'h08: begin d.alusrc = 1; d.regwrite = 1; end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic m_load_use();
    return m_idex.memread && m_idex.rt != 0 &&
           (m_idex.rt == inst[25:21] || m_idex.rt == inst[20:16]);
  endfunction

  function automatic logic m_hazard();
    return m_load_use() && !flush;
  endfunction

  task automatic tick();
    idex_t nxt;
    @(posedge clk);
    nxt = (flush || m_load_use()) ? idex_t'(0) : m_decode();
    if (wb_we && wb_reg != 0) m_rf[wb_reg] = wb_data;
    m_idex = nxt;
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_idex = '0;
  endtask

  task automatic test_reset();
    inst = NOP_INST; newpc = 32'd0; flush = 0; wb_we = 0; wb_reg = 0; wb_data = 0;
    reset = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs !== idex_t'(0)) $display("FAIL reset_idex got=%h want=0", obs);
    else passed++;
    total++;
    if (hazard !== 1'b0) $display("FAIL reset_hazard got=%b want=0", hazard);
    else passed++;
    reset = 1;
    #1;
  endtask

  task automatic test_add();
    wb_we = 1; wb_reg = 1; wb_data = 32'd5; inst = NOP_INST;
    tick();
    wb_reg = 2; wb_data = 32'd7;
    tick();
    wb_we = 0; inst = 32'h00221820; newpc = 32'h0000_1004;
    tick();
    total++;
    if (obs !== m_idex) $display("FAIL add_model got=%h want=%h", obs, m_idex);
    else passed++;
    total++;
    if ({o_rd1, o_rd2, o_rd, o_regdst, o_regwrite, o_aluop} !== {32'd5, 32'd7, 5'd3, 1'b1, 1'b1, 2'b10})
      $display("FAIL add_fields got rd1=%h rd2=%h rd=%0d regdst=%b regwrite=%b aluop=%b want 5 7 3 1 1 10",
               o_rd1, o_rd2, o_rd, o_regdst, o_regwrite, o_aluop);
    else passed++;
  endtask

  task automatic test_bypass();
    wb_we = 1; wb_reg = 4; wb_data = 32'hDEADBEEF; inst = 32'h00800020;
    tick();
    wb_we = 0;
    total++;
    if (o_rd1 !== 32'hDEADBEEF) $display("FAIL bypass_rd1 got=%h want=deadbeef", o_rd1);
    else passed++;
    total++;
    if (obs !== m_idex) $display("FAIL bypass_model got=%h want=%h", obs, m_idex);
    else passed++;
  endtask

  task automatic test_load_use();
    flush = 0; wb_we = 0; inst = 32'h8C220000;
    tick();
    inst = 32'h00421820;
    #1;
    total++;
    if (hazard !== 1'b1 || m_hazard() !== 1'b1) $display("FAIL lu_hazard got=%b want=1", hazard);
    else passed++;
    tick();
    total++;
    if (obs[151:143] !== 9'd0 || obs !== m_idex) $display("FAIL lu_bubble got=%h want=%h", obs, m_idex);
    else passed++;
    total++;
    if (hazard !== 1'b0) $display("FAIL lu_release got=%b want=0", hazard);
    else passed++;
    tick();
    total++;
    if (obs !== m_idex || o_regwrite !== 1'b1 || o_rd !== 5'd3)
      $display("FAIL lu_issue got=%h want=%h", obs, m_idex);
    else passed++;
  endtask

  task automatic test_flush_stall();
    inst = 32'h8C220000;
    tick();
    inst = 32'h00421820; flush = 1;
    #1;
    total++;
    if (hazard !== 1'b0) $display("FAIL flush_hazard got=%b want=0", hazard);
    else passed++;
    tick();
    flush = 0;
    total++;
    if (obs[151:143] !== 9'd0 || obs !== m_idex) $display("FAIL flush_bubble got=%h want=%h", obs, m_idex);
    else passed++;
  endtask

  task automatic test_zero_imm();
    wb_we = 1; wb_reg = 0; wb_data = 32'hFFFFFFFF; inst = 32'h00000020;
    tick();
    wb_we = 0;
    total++;
    if (o_rd1 !== 32'd0 || o_rd2 !== 32'd0) $display("FAIL zero_reg got rd1=%h rd2=%h want 0 0", o_rd1, o_rd2);
    else passed++;
    inst = 32'h0000_0020;
    tick();
    total++;
    if (o_rd1 !== 32'd0) $display("FAIL zero_stored got=%h want=0", o_rd1);
    else passed++;
    inst = 32'h2021FFFC;
    tick();
    total++;
    if (o_imm !== 32'hFFFFFFFC || o_alusrc !== 1'b1 || obs !== m_idex)
      $display("FAIL addi_imm got imm=%h alusrc=%b want fffffffc 1", o_imm, o_alusrc);
    else passed++;
  endtask

  task automatic test_random();
    logic [5:0] ops [6];
    int errs = 0;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h3F};
    for (int n = 0; n < 400; n++) begin
      inst = $urandom;
      inst[31:26] = ops[$urandom_range(0, 5)];
      inst[25:21] = 5'($urandom_range(0, 5));
      inst[20:16] = 5'($urandom_range(0, 5));
      newpc   = $urandom;
      flush   = ($urandom_range(0, 7) == 0);
      wb_we   = $urandom_range(0, 1) == 1;
      wb_reg  = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      #1;
      total++;
      if (hazard !== m_hazard()) begin
        errs++;
        if (errs < 10) $display("FAIL rand_hazard n=%0d got=%b want=%b", n, hazard, m_hazard());
      end else passed++;
      tick();
      total++;
      if (obs !== m_idex) begin
        errs++;
        if (errs < 10) $display("FAIL rand_idex n=%0d got=%h want=%h", n, obs, m_idex);
      end else passed++;
    end
    flush = 0; wb_we = 0;
  endtask

  task automatic test_async_reset();
    inst = 32'h8C220000;
    tick();
    inst = 32'h00421820;
    #1;
    total++;
    if (hazard !== 1'b1 || obs === idex_t'(0)) $display("FAIL pre_reset got hz=%b idex=%h want hz=1 nonzero", hazard, obs);
    else passed++;
    #2;
    reset = 0;
    #1;
    total++;
    if (obs !== idex_t'(0)) $display("FAIL async_reset_idex got=%h want=0", obs);
    else passed++;
    total++;
    if (hazard !== 1'b0) $display("FAIL async_reset_hazard got=%b want=0", hazard);
    else passed++;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1;
    inst = 32'h00221820;
    tick();
    total++;
    if (o_rd1 !== 32'd0 || obs !== m_idex) $display("FAIL rf_cleared got rd1=%h want=0", o_rd1);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_bypass();
    test_load_use();
    test_flush_stall();
    test_zero_imm();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
